simm_burst_master: RTL and testbench

//  Bus initiator for the SIMM DRAM path: turns a single internal request (DMA/video fetch) into 1-4

---
 rtl/simm_bus_pkg.sv | 21 ++
 rtl/simm_beat_addr.sv | 28 ++
 rtl/simm_burst_master.sv | 214 +++++++++++++++++++++
 tb/tb_simm_burst_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simm_bus_pkg.sv
// Shared definitions for the SIMM bus initiator: FSM encoding, line/beat geometry, read byte mask.
package simm_bus_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned BEAT_IDX_W = 2;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned BEAT_BYTES = 4;

    localparam logic [SEL_W-1:0] RD_BYTE_SEL = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_LATCH   = 3'd3,
        ST_RECOVER = 3'd4
    } bus_state_t;

endpackage

// File: rtl/simm_beat_addr.sv
// Bus address of a given beat of a burst: wraps inside the 16-byte line or advances linearly.
module simm_beat_addr
    import simm_bus_pkg::*;
#(
    parameter int unsigned WRAP_LINE = 1
) (
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    output logic [ADDR_W-1:0]     beat_addr_c
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] linear;

    always_comb begin
        offset = ADDR_W'(beat_idx) * ADDR_W'(BEAT_BYTES);
        linear = start_addr + offset;
        if (WRAP_LINE != 0) begin
            // line base stays fixed, only the in-line offset rolls over
            beat_addr_c = (start_addr & ~LINE_MASK) | (linear & LINE_MASK);
        end else begin
            beat_addr_c = linear;
        end
    end

endmodule

// File: rtl/simm_burst_master.sv
// SIMM bus initiator: one internal request becomes 1-4 longword strobe cycles, each completed by
// waitstate going low, with per-beat read capture / write handshakes and a WAIT timeout.
module simm_burst_master
    import simm_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned WRAP_LINE      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [BEAT_IDX_W-1:0] req_beats,
    input  logic [SEL_W-1:0]      req_byte_sel,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_next,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cs,
    output logic                  as,
    output logic                  ds,
    output logic                  rn_w,
    output logic [ADDR_W-1:0]     addr,
    output logic [SEL_W-1:0]      byte_selects,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_oe,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  waitstate
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    bus_state_t              state_q, state_d;
    logic [ADDR_W-1:0]       start_q, start_d;
    logic                    write_q, write_d;
    logic [BEAT_IDX_W-1:0]   beats_q, beats_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    strobe_q, strobe_d;
    logic                    rn_w_q, rn_w_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [SEL_W-1:0]        bs_q, bs_d;
    logic [DATA_W-1:0]       dout_q, dout_d;
    logic                    oe_q, oe_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    wr_next_q, wr_next_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       beat_addr_c;

    simm_beat_addr #(
        .WRAP_LINE (WRAP_LINE)
    ) u_beat_addr (
        .start_addr  (start_q),
        .beat_idx    (beat_q),
        .beat_addr_c (beat_addr_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            write_q    <= 1'b0;
            beats_q    <= '0;
            sel_q      <= '0;
            beat_q     <= '0;
            to_cnt_q   <= '0;
            strobe_q   <= 1'b0;
            rn_w_q     <= 1'b1;
            addr_q     <= '0;
            bs_q       <= '0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_next_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            write_q    <= write_d;
            beats_q    <= beats_d;
            sel_q      <= sel_d;
            beat_q     <= beat_d;
            to_cnt_q   <= to_cnt_d;
            strobe_q   <= strobe_d;
            rn_w_q     <= rn_w_d;
            addr_q     <= addr_d;
            bs_q       <= bs_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_next_q  <= wr_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        write_d    = write_q;
        beats_d    = beats_q;
        sel_d      = sel_q;
        beat_d     = beat_q;
        to_cnt_d   = to_cnt_q;
        strobe_d   = strobe_q;
        rn_w_d     = rn_w_q;
        addr_d     = addr_q;
        bs_d       = bs_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_next_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    start_d = req_addr & ~ADDR_W'(BEAT_BYTES - 1);
                    write_d = req_write;
                    beats_d = req_beats;
                    sel_d   = req_byte_sel;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // waitstate is deliberately not looked at here: a low value is stale
                addr_d   = beat_addr_c;
                rn_w_d   = ~write_q;
                bs_d     = write_q ? sel_q : RD_BYTE_SEL;
                oe_d     = write_q;
                if (write_q) begin
                    dout_d = wr_data;
                end
                strobe_d = 1'b1;
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!waitstate) begin
                    strobe_d = 1'b0;
                    oe_d     = 1'b0;
                    if (write_q) begin
                        wr_next_d = 1'b1;
                    end else begin
                        rd_data_d  = data_in;
                        rd_valid_d = 1'b1;
                    end
                    state_d = ST_LATCH;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    strobe_d = 1'b0;
                    oe_d     = 1'b0;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                // controller must be back in idle before the next address strobe
                if (waitstate) begin
                    if (beat_q == beats_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_IDX_W'(1);
                        state_d = ST_ASSERT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cs           = strobe_q;
    assign as           = strobe_q;
    assign ds           = strobe_q;
    assign rn_w         = rn_w_q;
    assign addr         = addr_q;
    assign byte_selects = bs_q;
    assign data_out     = dout_q;
    assign data_oe      = oe_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign wr_next      = wr_next_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_simm_burst_master.sv
// Directed bench: two initiators (line-wrap and linear) sharing a simple SIMM controller model.
module tb_simm_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_p = 1'b0;
    logic        req_write_p = 1'b0;
    logic [31:0] req_addr_p = '0;
    logic [1:0]  req_beats_p = '0;
    logic [3:0]  req_sel_p = '0;
    logic [31:0] wtab [0:3];
    int          wi = 0;
    logic [31:0] wr_data_p;

    logic        ws;
    int          mcnt;
    int          lat = 2;
    logic        stuck = 1'b0;

    int errors = 0;
    int checks = 0;

    logic        wr_next0, rd_valid0, busy0, done0, err0, cs0, as0, ds0, rnw0, oe0;
    logic [31:0] rd_data0, addr0, dout0;
    logic [3:0]  bs0;
    logic        wr_next1, rd_valid1, busy1, done1, err1, cs1, as1, ds1, rnw1, oe1;
    logic [31:0] rd_data1, addr1, dout1;
    logic [3:0]  bs1;
    logic [31:0] data_in_m;

    always #5 clk = ~clk;

    assign wr_data_p = wtab[wi & 3];

    simm_burst_master #(.TIMEOUT_CYCLES(64), .WRAP_LINE(1)) dut0 (
        .clock(clk), .reset(rst), .req(req_p & ~sel), .req_write(req_write_p),
        .req_addr(req_addr_p), .req_beats(req_beats_p), .req_byte_sel(req_sel_p),
        .wr_data(wr_data_p), .wr_next(wr_next0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .busy(busy0), .done(done0), .err(err0), .cs(cs0), .as(as0), .ds(ds0), .rn_w(rnw0),
        .addr(addr0), .byte_selects(bs0), .data_out(dout0), .data_oe(oe0),
        .data_in(data_in_m), .waitstate(ws)
    );

    simm_burst_master #(.TIMEOUT_CYCLES(64), .WRAP_LINE(0)) dut1 (
        .clock(clk), .reset(rst), .req(req_p & sel), .req_write(req_write_p),
        .req_addr(req_addr_p), .req_beats(req_beats_p), .req_byte_sel(req_sel_p),
        .wr_data(wr_data_p), .wr_next(wr_next1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy(busy1), .done(done1), .err(err1), .cs(cs1), .as(as1), .ds(ds1), .rn_w(rnw1),
        .addr(addr1), .byte_selects(bs1), .data_out(dout1), .data_oe(oe1),
        .data_in(data_in_m), .waitstate(ws)
    );

    wire        as_m    = sel ? as1 : as0;
    wire        cs_m    = sel ? cs1 : cs0;
    wire        ds_m    = sel ? ds1 : ds0;
    wire [31:0] addr_m  = sel ? addr1 : addr0;
    wire [3:0]  bs_m    = sel ? bs1 : bs0;
    wire        rnw_m   = sel ? rnw1 : rnw0;
    wire [31:0] dout_m  = sel ? dout1 : dout0;
    wire        oe_m    = sel ? oe1 : oe0;
    wire        rdv_m   = sel ? rd_valid1 : rd_valid0;
    wire [31:0] rdd_m   = sel ? rd_data1 : rd_data0;
    wire        wrn_m   = sel ? wr_next1 : wr_next0;
    wire        done_m  = sel ? done1 : done0;
    wire        err_m   = sel ? err1 : err0;
    wire        busy_m  = sel ? busy1 : busy0;

    assign data_in_m = addr_m ^ 32'h5A5A_0000;

    // Controller model: waitstate drops lat cycles after as rises, returns high once as falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ws   <= 1'b1;
            mcnt <= 0;
        end else if (!as_m) begin
            ws   <= 1'b1;
            mcnt <= 0;
        end else if (!stuck) begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 >= lat) ws <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] addr_log [0:7];
    logic [31:0] dout_log [0:7];
    logic [31:0] rd_log   [0:7];
    logic [3:0]  bs_log   [0:7];
    logic        rnw_log  [0:7];
    logic        oe_log   [0:7];
    int n_as = 0, n_as_cyc = 0, n_rd = 0, n_wr = 0, n_done = 0, n_err = 0;
    logic as_prev = 1'b0;

    always @(negedge clk) begin
        check("strobes_equal", {30'd0, cs_m, ds_m}, {30'd0, as_m, as_m});
        check("done_err_excl", {31'd0, done_m & err_m}, 32'd0);
        if (as_m && !as_prev) begin
            if (n_as < 8) begin
                addr_log[n_as] = addr_m;
                dout_log[n_as] = dout_m;
                bs_log[n_as]   = bs_m;
                rnw_log[n_as]  = rnw_m;
                oe_log[n_as]   = oe_m;
            end
            n_as++;
        end
        if (as_m) n_as_cyc++;
        if (rdv_m) begin
            if (n_rd < 8) rd_log[n_rd] = rdd_m;
            n_rd++;
        end
        if (wrn_m) begin
            n_wr++;
            wi++;
        end
        if (done_m) n_done++;
        if (err_m) n_err++;
        as_prev = as_m;
    end

    task automatic clear_logs();
        n_as = 0; n_as_cyc = 0; n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; wi = 0;
    endtask

    task automatic issue(input logic s, input logic w, input logic [31:0] a,
                         input logic [1:0] nb, input logic [3:0] bsel);
        @(negedge clk);
        sel = s;
        clear_logs();
        req_write_p = w; req_addr_p = a; req_beats_p = nb; req_sel_p = bsel;
        req_p = 1'b1;
        @(negedge clk);
        req_p = 1'b0;
        check("busy_after_req", {31'd0, busy_m}, 32'd1);
    endtask

    task automatic wait_end();
        bit seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_m || err_m) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("burst_end_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        wtab[0] = 32'hDEAD_0001; wtab[1] = 32'hBEEF_0002;
        wtab[2] = 32'hCAFE_0003; wtab[3] = 32'hF00D_0004;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // cs,as,ds,rn_w,oe,busy,done,err,rd_valid,wr_next
        check("reset_ctrl", {22'd0, cs0, as0, ds0, rnw0, oe0, busy0, done0, err0, rd_valid0, wr_next0},
              32'b00_0100_0000);
        check("reset_addr", addr0, 32'd0);
        check("reset_bs", {28'd0, bs0}, 32'd0);
        check("reset_dout", dout0, 32'd0);

        // single read beat, line-wrap unit
        issue(1'b0, 1'b0, 32'h0000_1000, 2'd0, 4'h0);
        wait_end();
        check("r1_nas", n_as, 1);
        check("r1_addr", addr_log[0], 32'h0000_1000);
        check("r1_bs", {28'd0, bs_log[0]}, 32'hF);
        check("r1_rnw", {31'd0, rnw_log[0]}, 32'd1);
        check("r1_nrd", n_rd, 1);
        check("r1_data", rd_log[0], 32'h5A5A_1000);
        check("r1_done", n_done, 1);
        check("r1_busy", {31'd0, busy_m}, 32'd0);

        // 4-beat critical-word-first read wrapping inside the line
        issue(1'b0, 1'b0, 32'h0000_100C, 2'd3, 4'h0);
        wait_end();
        check("r4_nas", n_as, 4);
        check("r4_addr0", addr_log[0], 32'h0000_100C);
        check("r4_addr1", addr_log[1], 32'h0000_1000);
        check("r4_addr2", addr_log[2], 32'h0000_1004);
        check("r4_addr3", addr_log[3], 32'h0000_1008);
        check("r4_nrd", n_rd, 4);
        check("r4_data0", rd_log[0], 32'h5A5A_100C);
        check("r4_data1", rd_log[1], 32'h5A5A_1000);
        check("r4_data3", rd_log[3], 32'h5A5A_1008);
        check("r4_done", n_done, 1);

        // 3-beat linear write crossing the top of the address space
        issue(1'b1, 1'b1, 32'hFFFF_FFF8, 2'd2, 4'b0011);
        wait_end();
        check("w3_nas", n_as, 3);
        check("w3_addr0", addr_log[0], 32'hFFFF_FFF8);
        check("w3_addr1", addr_log[1], 32'hFFFF_FFFC);
        check("w3_addr2", addr_log[2], 32'h0000_0000);
        check("w3_bs", {28'd0, bs_log[1]}, 32'h3);
        check("w3_rnw_oe", {30'd0, rnw_log[2], oe_log[2]}, 32'b01);
        check("w3_dout0", dout_log[0], 32'hDEAD_0001);
        check("w3_dout1", dout_log[1], 32'hBEEF_0002);
        check("w3_dout2", dout_log[2], 32'hCAFE_0003);
        check("w3_nwr", n_wr, 3);
        check("w3_done", n_done, 1);
        check("w3_oe_idle", {31'd0, oe_m}, 32'd0);

        // long refresh stall inside WAIT completes without error
        lat = 10;
        issue(1'b0, 1'b0, 32'h0000_2004, 2'd0, 4'h0);
        wait_end();
        check("rf_err", n_err, 0);
        check("rf_done", n_done, 1);
        check("rf_data", rd_log[0], 32'h5A5A_2004);

        // waitstate stuck high: abort after 64 WAIT cycles
        stuck = 1'b1;
        issue(1'b0, 1'b0, 32'h0000_3000, 2'd1, 4'h0);
        wait_end();
        check("to_wait_cycles", n_as_cyc, 64);
        check("to_err", n_err, 1);
        check("to_done", n_done, 0);
        check("to_nrd", n_rd, 0);
        check("to_idle", {30'd0, as_m, busy_m}, 32'd0);
        stuck = 1'b0;

        // reset during WAIT of the second beat
        lat = 5;
        issue(1'b0, 1'b0, 32'h0000_4000, 2'd3, 4'h0);
        for (int i = 0; i < 200 && n_as < 2; i++) @(negedge clk);
        check("rst_reached_beat2", n_as, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async_strobes", {28'd0, cs0, as0, ds0, busy0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nrd", n_rd, 1);
        check("rst_no_done_err", n_done + n_err, 0);

        lat = 2;
        issue(1'b0, 1'b0, 32'h0000_5008, 2'd0, 4'h0);
        wait_end();
        check("post_rst_done", n_done, 1);
        check("post_rst_data", rd_log[0], 32'h5A5A_5008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
